// File: rtl/dmem_pkg.sv
// dmem_pkg: shared FSM state encoding and default error data for the data memory bridge
package dmem_pkg;
  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
  localparam logic [31:0] DMEM_ERR_DATA = 32'hDEADBEEF;
endpackage

// File: rtl/dmem_timeout_ctr.sv
// dmem_timeout_ctr: counts bus wait cycles; expired marks the last allowed REQ cycle
module dmem_timeout_ctr #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int W = $clog2(TIMEOUT + 1);
  logic [W-1:0] cnt;
  // wait counter, saturates once the timeout point is reached
  always_ff @(posedge clk or negedge reset)
    if (!reset) cnt <= '0;
    else if (clear) cnt <= '0;
    else if (enable && !expired) cnt <= cnt + 1'b1;
  assign expired = cnt == W'(TIMEOUT - 1);
endmodule

// File: rtl/data_mem_bridge.sv
// data_mem_bridge: core load/store to req/ack bus bridge with timeout; DMEM_WRITE_BUFFER_EN adds a posted-write buffer
module data_mem_bridge import dmem_pkg::*; #(
  parameter int          TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = DMEM_ERR_DATA
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [3:0]  byte_enable,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        stall,
  output logic        bus_req,
  output logic        bus_we,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        timeout_err
);
`ifdef DMEM_WRITE_BUFFER_EN
  localparam logic WB = 1'b1;
`else
  localparam logic WB = 1'b0;
`endif
  state_t state;
  logic   drain;
  logic   expired;
  logic   req_in;
  assign req_in = mem_read | mem_write;
  dmem_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_ctr (
    .clk(clk),
    .reset(reset),
    .clear(state == IDLE),
    .enable(state == REQ && !bus_ack),
    .expired(expired)
  );
  // a posted store (drain) only holds the core off when it presents another access
  assign stall = state == IDLE ? req_in && !(WB && mem_write) :
                 state == REQ  ? (drain ? req_in : 1'b1) : drain && req_in;
  // bridge FSM: latch the access, run the bus handshake, retire for one cycle
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state       <= IDLE;
      drain       <= 1'b0;
      read_data   <= '0;
      timeout_err <= 1'b0;
      bus_req     <= 1'b0;
      bus_we      <= 1'b0;
      bus_be      <= '0;
      bus_addr    <= '0;
      bus_wdata   <= '0;
    end else
      case (state)
        IDLE: if (req_in) begin
          state     <= REQ;
          drain     <= WB && mem_write;
          bus_req   <= 1'b1;
          bus_we    <= mem_write;
          bus_be    <= byte_enable;
          bus_addr  <= addr & ~32'h3;
          bus_wdata <= write_data;
        end
        REQ: if (bus_ack || expired) begin
          state   <= RESP;
          bus_req <= 1'b0;
          if (!bus_ack) timeout_err <= 1'b1;
          if (!bus_we) read_data <= bus_ack ? bus_rdata : ERR_DATA;
        end
        RESP: begin
          state <= IDLE;
          drain <= 1'b0;
        end
        default: state <= IDLE;
      endcase
endmodule

// File: doc/data_mem_bridge.md
DATA_MEM_BRIDGE -- requirements
Module: data_mem_bridge

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, meaning maximum cycles to wait for bus_ack before aborting an access.
REQ-002 SHALL have parameter ERR_DATA, default 32'hDEADBEEF, meaning read_data returned on a timed-out load.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 mem_read  input  1  core load request.
REQ-006 mem_write  input  1  core store request.
REQ-007 byte_enable  input  4  core byte lanes.
REQ-008 addr  input  32  core byte address (alu_result).
REQ-009 write_data  input  32  core lane-aligned store data.
REQ-010 read_data  output  32  registered load data to core.
REQ-011 stall  output  1  core shall hold pc and all inputs while high.
REQ-012 bus_req, bus_we  output  1 each  bus request and write qualifier.
REQ-013 bus_be  output  4; bus_addr  output  32 (bits [1:0] forced 0); bus_wdata  output  32.
REQ-014 bus_ack  input  1; bus_rdata  input  32 (valid when bus_ack high).
REQ-015 timeout_err  output  1  sticky flag, set by any timed-out access.

Function
REQ-016 FSM states: IDLE, REQ, RESP; one-hot or binary encoding, implementer's choice.
REQ-017 IDLE: if mem_read or mem_write, latch addr/byte_enable/write_data/op, go to REQ; stall high combinationally that cycle.
REQ-018 REQ: bus_req high, bus_we/bus_be/bus_addr/bus_wdata from latched values, held stable until bus_ack or timeout; stall high.
REQ-019 bus_ack in REQ: load captures bus_rdata into read_data; go to RESP.
REQ-020 Wait counter clears on entry to REQ and increments each REQ cycle without ack; reaching TIMEOUT: bus_req drops, timeout_err set, load returns ERR_DATA, go to RESP.
REQ-021 RESP: stall low for exactly one cycle (core retires instruction); unconditionally go to IDLE; new request not accepted in RESP.
REQ-022 Minimum load latency: 3 cycles request-to-retire (ack in first REQ cycle); each extra wait cycle adds one.
REQ-023 mem_read and mem_write both high: treated as store.
REQ-024 bus_ack outside REQ: ignored, no state change.
REQ-025 read_data holds its last value except on load completion.

Reset
REQ-026 reset low: state IDLE, counter 0, read_data 0, timeout_err 0, bus_req 0, bus_we 0, bus_be 0, bus_addr 0, bus_wdata 0, buffer empty; applies immediately, aborting any in-flight access without completion.

Configuration
REQ-027 Macro DMEM_WRITE_BUFFER_EN compiles in a one-entry posted-write buffer.
REQ-028 With macro: store in IDLE with buffer empty is captured, stall stays low, core retires in same cycle; buffer drains via REQ independently; any access while buffer full stalls until drained and then follows REQ-017.
REQ-029 With macro: a timed-out buffered store sets timeout_err only.
REQ-030 Without macro: stores follow REQ-017..REQ-021 identically to loads.

Structure
REQ-031 State encoding and the default ERR_DATA constant SHALL live in shared package dmem_pkg.
REQ-032 Wait counter SHALL be sub-module dmem_timeout_ctr (clear, enable, expired output), width clog2(TIMEOUT+1).

Verification
REQ-033 Load addr=0x100, be=1111, ack after 2 wait cycles with rdata=0x12345678 -> stall high 4 cycles, read_data=0x12345678 in RESP cycle.
REQ-034 Store addr=0x203, be=1000, wdata=0xAB000000, immediate ack -> bus_addr=0x200, bus_be=1000, bus_we=1; stall low on cycle 3.
REQ-035 Load with no ack, TIMEOUT=4 -> bus_req drops after 4 REQ cycles, read_data=0xDEADBEEF, timeout_err=1 until reset.
REQ-036 reset low during REQ -> bus_req 0 asynchronously, state IDLE, later ack ignored.
REQ-037 With DMEM_WRITE_BUFFER_EN: store then load back-to-back, ack delayed 3 cycles -> store no stall; load stalls until drain, then normal load.
REQ-038 mem_read and mem_write both high -> single bus write, bus_we=1.
